sn_req_responder: RTL

- Subordinate-node endpoint on the NoC. Terminates the request channel from the request node and drives the data channel back to it.
- Both channels use credit-based flow control. `pre_*` is a one-cycle credit-return pulse; `v_*` qualifies a flit.
- Buffers incoming requests in a FIFO and services them in order against a local word-addressed memory.
- Returns exactly one data flit per request.

---
 rtl/sn_req_responder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/sn_req_responder.sv
// Subordinate-node request responder: credit-based request intake FIFO,
// serialized memory access, one credit-gated data flit per request.
module sn_req_responder #(
  parameter int ADDR_W        = 4,
  parameter int DATA_W        = 32,
  parameter int ID_W          = 4,
  parameter int REQ_DEPTH     = 4,
  parameter int MAX_DATA_CRED = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         pre_rx_req,
  input  logic                         v_rx_req,
  input  logic [ID_W+ADDR_W+DATA_W:0]  rx_req,
  input  logic                         pre_tx_data,
  output logic                         v_tx_data,
  output logic [ID_W+DATA_W-1:0]       tx_data,
  output logic                         err
);

  localparam int REQ_W  = 1 + ID_W + ADDR_W + DATA_W;
  localparam int PTR_W  = $clog2(REQ_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int CRED_W = $clog2(MAX_DATA_CRED + 1);
  localparam int MEM_D  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_ACCESS,
    S_SEND
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [REQ_W-1:0]  r_fifo [REQ_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_init_cnt;
  logic [CRED_W-1:0] r_cred;
  logic [DATA_W-1:0] r_mem [MEM_D];

  logic              r_op;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_payload;
  logic              r_pre;
  logic              r_v;
  logic              r_err;

  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_send;
  logic              w_cred_ovf;
  logic [REQ_W-1:0]  w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(REQ_DEPTH));
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push  = v_rx_req && (!w_full || w_pop);
  assign w_drop  = v_rx_req && w_full && !w_pop;
  assign w_head  = r_fifo[r_rptr];

  assign w_send     = (r_state == S_SEND) && (r_cred != '0);
  assign w_cred_ovf = pre_tx_data && !w_send &&
                      (r_cred == CRED_W'(MAX_DATA_CRED));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_INIT: begin
        if (r_init_cnt == PTR_W'(REQ_DEPTH - 1))
          w_next = S_IDLE;
      end
      S_IDLE: begin
        if (!w_empty)
          w_next = S_ACCESS;
      end
      S_ACCESS: w_next = S_SEND;
      S_SEND: begin
        if (w_send)
          w_next = S_IDLE;
      end
      default: w_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_INIT)
        r_init_cnt <= r_init_cnt + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_fifo[r_wptr] <= rx_req;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)
        r_rptr <= r_rptr + PTR_W'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op    <= 1'b0;
      r_id    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_pop) begin
      r_op    <= w_head[REQ_W-1];
      r_id    <= w_head[ID_W+ADDR_W+DATA_W-1 -: ID_W];
      r_addr  <= w_head[ADDR_W+DATA_W-1 -: ADDR_W];
      r_wdata <= w_head[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_ACCESS && r_op)
      r_mem[r_addr] <= r_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_payload <= '0;
    end else if (r_state == S_ACCESS) begin
      r_payload <= r_op ? r_wdata : r_mem[r_addr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cred <= '0;
    end else if (pre_tx_data && !w_send) begin
      if (!w_cred_ovf)
        r_cred <= r_cred + CRED_W'(1);
    end else if (!pre_tx_data && w_send) begin
      r_cred <= r_cred - CRED_W'(1);
    end
  end

  // ACCESS always follows exactly one pop, so it doubles as the return strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre <= 1'b0;
      r_v   <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_pre <= (r_state == S_INIT) || (r_state == S_ACCESS);
      r_v   <= w_send;
      r_err <= r_err | w_drop | w_cred_ovf;
    end
  end

  assign pre_rx_req = r_pre;
  assign v_tx_data  = r_v;
  assign tx_data    = {r_id, r_payload};
  assign err        = r_err;

endmodule
